ram_fifo_ctrl: RTL and testbench
================================

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10; RAM depth DEPTH = 2^ADDR_WIDTH.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-4, almost-full level.
REQ-004 SHALL have port clk, input, 1, the only clock; one clock, synchronous active-low reset.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have ports s_valid (in, 1), s_ready (out, 1) and s_data (in, DATA_WIDTH), the write-side handshake.
REQ-007 SHALL have ports m_valid (out, 1), m_ready (in, 1) and m_data (out, DATA_WIDTH), the read-side handshake.
REQ-008 SHALL have ports ram_ena, ram_wea (out, 1), ram_addra (out, ADDR_WIDTH) and ram_dina (out, DATA_WIDTH), driving RAM port A.
REQ-009 SHALL have ports ram_enb, ram_web (out, 1) and ram_addrb (out, ADDR_WIDTH), driving RAM port B, plus ram_doutb (in, DATA_WIDTH), the registered port-B read data.
REQ-010 SHALL have ports empty (out, 1), full (out, 1), level (out, ADDR_WIDTH+2) and almost_full (out, 1), the status outputs.

Function
REQ-011 SHALL accept a push when s_valid && s_ready and the same cycle drive ram_ena=ram_wea=1, ram_addra=wr_ptr, ram_dina=s_data.
REQ-012 SHALL drive s_ready = (ram_cnt != DEPTH), decoded only from registers; full = !s_ready.
REQ-013 SHALL tie ram_web=0; a read is issued (ram_enb=1, ram_addrb=rd_ptr) when ram_cnt != 0 and obuf_cnt + rd_inflight - pop < 2.
REQ-014 SHALL set rd_inflight one cycle after issue and capture ram_doutb into a 2-entry output buffer in that cycle; RAM read latency is fixed at 1 cycle.
REQ-015 SHALL drive m_valid = (obuf_cnt != 0) and m_data = head of obuf; pop = m_valid && m_ready.
REQ-016 SHALL hold m_data stable while m_valid && !m_ready.
REQ-017 SHALL update pointers as follows: wr_ptr and rd_ptr wrap from DEPTH-1 to 0; ram_cnt +1 on push, -1 on issue, unchanged on both.
REQ-018 SHALL never write and read the same RAM address in one cycle; this is guaranteed by the ram_cnt gating.
REQ-019 SHALL preserve data order for simultaneous push, issue, capture and pop.
REQ-020 SHALL have total capacity DEPTH+2 words (RAM plus output buffer).
REQ-021 SHALL have push-to-m_valid latency of 3 cycles when empty: push at cycle 0, read issued at cycle 1, captured at cycle 2, m_valid=1 at cycle 3.
REQ-022 SHALL sustain 1 word/cycle throughput when s_valid and m_ready are held high.
REQ-023 SHALL assert empty when ram_cnt==0 && obuf_cnt==0 && !rd_inflight.

Reset
REQ-024 SHALL on rst_n=0 at a clk edge clear wr_ptr, rd_ptr, ram_cnt, obuf_cnt and rd_inflight.
REQ-025 SHALL during and after reset drive s_ready=1, m_valid=0, empty=1, full=0, level=0, almost_full=0, all RAM enables 0, and all addresses and data 0.
REQ-026 SHALL on reset mid-operation discard all queued and in-flight words; RAM contents are not cleared.

Configuration
REQ-027 SHALL, with macro RAM_FIFO_LEVEL_EN defined, implement a registered occupancy counter: level = ram_cnt + obuf_cnt + rd_inflight, and almost_full = (level >= AF_THRESH).
REQ-028 SHALL, without RAM_FIFO_LEVEL_EN, tie level=0 and almost_full=0 and implement no counter logic; all other behaviour is unchanged.

Verification (ADDR_WIDTH=4, DEPTH=16)
REQ-029 SHALL cover the empty-push scenario: from reset, push 0xA5 at cycle 0 with m_ready=1 -> ram_enb=1, ram_addrb=0 at cycle 1; m_valid=1, m_data=0xA5 at cycle 3; empty=1 at cycle 4.
REQ-030 SHALL cover the fill scenario: m_ready=0, push 0..19 continuously -> 18 accepted, s_ready=0 after the 18th, full=1, level=18 (LEVEL_EN); then pop 18 words in order 0..17 and empty=1.
REQ-031 SHALL cover the streaming scenario: s_valid=m_ready=1 for 100 cycles, data 1..100 -> m_valid continuous from cycle 3, output 1..100 in order, no bubble.
REQ-032 SHALL cover the backpressure scenario: m_ready toggling 1,0,0,1 while pushing 40 words -> m_data stable when stalled, no loss or duplication, and pointers wrapping 15->0 twice.
REQ-033 SHALL cover the reset-mid-operation scenario: 10 words queued, rst_n=0 for 1 cycle -> next cycle m_valid=0, empty=1, s_ready=1, level=0; next push 0x3C emerges first.
REQ-034 SHALL cover the almost-full scenario: with LEVEL_EN and AF_THRESH=12, push 12 words with m_ready=0 -> almost_full=1 the cycle after the 12th push; pop 1 -> almost_full=0.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over an external dual-port RAM (1-cycle registered read) with a 2-entry output skid buffer.
// Optional registered occupancy/almost-full status under macro RAM_FIFO_LEVEL_EN.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int AF_THRESH  = (2**ADDR_WIDTH) - 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  ram_enb,
  output logic                  ram_web,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_doutb,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  almost_full
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         ram_cnt_q, ram_cnt_d;
  logic [1:0]            obuf_cnt_q, obuf_cnt_d;
  logic                  rd_inflight_q, rd_inflight_d;
  logic [1:0][DATA_WIDTH-1:0] obuf_q, obuf_d;
  logic                  push, pop, issue;
  logic [2:0]            ob_need;

  assign s_ready = (ram_cnt_q != DEPTH_C);
  assign full    = !s_ready;
  assign push    = rst_n && s_valid && s_ready;
  assign m_valid = rst_n && (obuf_cnt_q != 2'd0);
  assign m_data  = obuf_q[0];
  assign pop     = m_valid && m_ready;
  assign empty   = (ram_cnt_q == '0) && (obuf_cnt_q == 2'd0) && !rd_inflight_q;

  // Slots the output buffer will need once everything already committed lands.
  assign ob_need = {1'b0, obuf_cnt_q} + {2'b0, rd_inflight_q} - {2'b0, pop};
  assign issue   = rst_n && (ram_cnt_q != '0) && (ob_need < 3'd2);

  assign ram_ena   = push;
  assign ram_wea   = push;
  assign ram_addra = push ? wr_ptr_q : '0;
  assign ram_dina  = push ? s_data : '0;
  assign ram_enb   = issue;
  assign ram_web   = 1'b0;
  assign ram_addrb = issue ? rd_ptr_q : '0;

  assign wr_ptr_d      = push  ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d      = issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign ram_cnt_d     = ram_cnt_q + CW'(push) - CW'(issue);
  assign rd_inflight_d = issue;

  // Pop shifts the head out first, so a same-cycle capture lands behind any survivor.
  always_comb begin
    logic [1:0] cnt;
    obuf_d = obuf_q;
    cnt    = obuf_cnt_q;
    if (pop) begin
      obuf_d[0] = obuf_q[1];
      cnt       = cnt - 2'd1;
    end
    if (rd_inflight_q) begin
      obuf_d[cnt[0]] = ram_doutb;
      cnt            = cnt + 2'd1;
    end
    obuf_cnt_d = cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ram_cnt_q     <= '0;
      obuf_cnt_q    <= '0;
      rd_inflight_q <= 1'b0;
      obuf_q        <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ram_cnt_q     <= ram_cnt_d;
      obuf_cnt_q    <= obuf_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      obuf_q        <= obuf_d;
    end
  end

`ifdef RAM_FIFO_LEVEL_EN
  localparam logic [ADDR_WIDTH+1:0] AF_L = (ADDR_WIDTH+2)'(AF_THRESH);
  logic [ADDR_WIDTH+1:0] level_q, level_d;

  // Issue and capture only move words inside the FIFO; occupancy changes on push/pop alone.
  assign level_d = level_q + (ADDR_WIDTH+2)'(push) - (ADDR_WIDTH+2)'(pop);

  always_ff @(posedge clk) begin
    if (!rst_n) level_q <= '0;
    else        level_q <= level_d;
  end

  assign level       = level_q;
  assign almost_full = (level_q >= AF_L);
`else
  assign level       = '0;
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl (DEPTH=16) with a behavioural RAM and a queue scoreboard.
// Level/almost-full expectations follow whether RAM_FIFO_LEVEL_EN is defined.
module tb_ram_fifo_ctrl;
  localparam int DW = 32;
  localparam int AW = 4;
`ifdef RAM_FIFO_LEVEL_EN
  localparam bit LVL = 1'b1;
`else
  localparam bit LVL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, s_valid, s_ready, m_valid, m_ready;
  logic [DW-1:0] s_data, m_data, ram_dina, ram_doutb;
  logic          ram_ena, ram_wea, ram_enb, ram_web, empty, full, almost_full;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [AW+1:0] level;

  int errors = 0, checks = 0, pops = 0;
  int wr_wraps = 0, rd_wraps = 0;
  logic [AW-1:0] wa_prev = '0, ra_prev = '0;
  logic [DW-1:0] exp_q[$];
  logic          hold_vld = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic [DW-1:0] mem [16];

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_enb(ram_enb), .ram_web(ram_web), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb),
    .empty(empty), .full(full), .level(level), .almost_full(almost_full)
  );

  // Port A write, port B registered read (1-cycle latency).
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_enb) ram_doutb <= mem[ram_addrb];
  end

  // Scoreboard: accepted pushes enqueue, output handshakes dequeue and compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        checks++;
        if (!m_valid || m_data !== hold_data) begin
          errors++;
          $display("FAIL stall_hold: m_valid=%0b m_data=%0h required 1/%0h", m_valid, m_data, hold_data);
        end
      end
      hold_vld  = m_valid && !m_ready;
      hold_data = m_data;
      if (m_valid && m_ready) begin
        checks++;
        pops++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: m_data=%0h with nothing expected", m_data);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (m_data !== e) begin
            errors++;
            $display("FAIL sb_data: m_data=%0h required %0h", m_data, e);
          end
        end
      end
      if (s_valid && s_ready) exp_q.push_back(s_data);
      if (ram_ena && ram_enb) begin
        checks++;
        if (ram_addra == ram_addrb) begin
          errors++;
          $display("FAIL addr_collision: addra=%0d addrb=%0d required distinct", ram_addra, ram_addrb);
        end
      end
      if (ram_ena) begin
        if (wa_prev == 4'd15 && ram_addra == 4'd0) wr_wraps++;
        wa_prev = ram_addra;
      end
      if (ram_enb) begin
        if (ra_prev == 4'd15 && ram_addrb == 4'd0) rd_wraps++;
        ra_prev = ram_addrb;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    while (!empty && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_empty"}, empty, 1);
    step();
    check({name, "_sb_left"}, exp_q.size(), 0);
  endtask

  task automatic reset_outputs(input string name);
    check({name, "_s_ready"}, s_ready, 1);
    check({name, "_m_valid"}, m_valid, 0);
    check({name, "_empty"}, empty, 1);
    check({name, "_full"}, full, 0);
    check({name, "_level"}, level, 0);
    check({name, "_af"}, almost_full, 0);
    check({name, "_ram_en"}, {ram_ena, ram_wea, ram_enb, ram_web}, 0);
    check({name, "_ram_addr_data"}, {ram_addra, ram_addrb, ram_dina}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, p0, n;
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    step(); step();
    @(negedge clk);
    reset_outputs("in_reset");
    step();
    rst_n = 1'b1;
    @(negedge clk);
    reset_outputs("after_reset");
    step();

    // Empty push: enable at 1, data out at 3, empty again at 4.
    s_valid = 1'b1; s_data = 32'hA5; m_ready = 1'b1;
    @(negedge clk);
    check("ep_write", {ram_ena, ram_wea, ram_addra, ram_dina}, {2'b11, 4'd0, 32'hA5});
    step(); s_valid = 1'b0;
    @(negedge clk);
    check("ep_issue", {ram_enb, ram_addrb}, {1'b1, 4'd0});
    step();
    @(negedge clk);
    check("ep_c2_mvalid", m_valid, 0);
    step();
    @(negedge clk);
    check("ep_c3_out", {m_valid, m_data}, {1'b1, 32'hA5});
    step();
    @(negedge clk);
    check("ep_c4_empty", empty, 1);
    step();

    // Fill: 18 of 20 offered words fit.
    m_ready = 1'b0; acc = 0;
    for (int k = 0; k < 20; k++) begin
      s_valid = 1'b1; s_data = k;
      @(negedge clk);
      if (s_ready) acc++;
      step();
    end
    s_valid = 1'b0;
    @(negedge clk);
    check("fill_accepted", acc, 18);
    check("fill_s_ready", s_ready, 0);
    check("fill_full", full, 1);
    check("fill_level", level, LVL ? 18 : 0);
    check("fill_head", {m_valid, m_data}, {1'b1, 32'd0});
    step();
    p0 = pops;
    drain("fill");
    check("fill_pops", pops - p0, 18);

    // Streaming: 100 words, m_valid exactly on cycles 3..102.
    p0 = pops;
    m_ready = 1'b1;
    for (int c = 0; c < 105; c++) begin
      s_valid = (c < 100); s_data = c + 1;
      @(negedge clk);
      check($sformatf("stream_mvalid_c%0d", c), m_valid, (c >= 3 && c <= 102));
      step();
    end
    s_valid = 1'b0;
    check("stream_pops", pops - p0, 100);
    check("stream_sb_left", exp_q.size(), 0);

    // Backpressure: m_ready 1,0,0,1 while 40 words go through and wrap twice.
    wr_wraps = 0; rd_wraps = 0; p0 = pops; acc = 0; n = 0;
    s_valid = 1'b1; s_data = 32'h100;
    while ((acc < 40 || !empty) && n < 600) begin
      m_ready = (n % 4 == 0) || (n % 4 == 3);
      @(negedge clk);
      if (s_valid && s_ready) acc++;
      step();
      s_valid = (acc < 40); s_data = 32'h100 + acc;
      n++;
    end
    s_valid = 1'b0;
    check("bp_done_in_time", n < 600, 1);
    check("bp_pops", pops - p0, 40);
    check("bp_sb_left", exp_q.size(), 0);
    check("bp_wr_wraps", wr_wraps, 2);
    check("bp_rd_wraps", rd_wraps, 2);

    // Reset with 10 words queued; everything queued is discarded.
    m_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      s_valid = 1'b1; s_data = 32'h200 + k;
      step();
    end
    s_valid = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_mvalid", m_valid, 0);
    check("rst_mid_empty", empty, 1);
    check("rst_mid_s_ready", s_ready, 1);
    check("rst_mid_level", level, 0);
    step();
    s_valid = 1'b1; s_data = 32'h3C; m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rst_first_out", {m_valid, m_data}, {1'b1, 32'h3C});
    step();
    drain("rst");

    // Almost-full: threshold 12 crossed the cycle after the 12th push.
    m_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      s_valid = 1'b1; s_data = 32'h300 + k;
      @(negedge clk);
      if (k == 11) check("af_before_12th", almost_full, 0);
      step();
    end
    s_valid = 1'b0;
    @(negedge clk);
    check("af_after_12th", almost_full, LVL);
    check("af_level", level, LVL ? 12 : 0);
    step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    @(negedge clk);
    check("af_after_pop", almost_full, 0);
    check("af_level_pop", level, LVL ? 11 : 0);
    step();
    drain("af");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
